// File: rtl/shreg_pkg.sv
// Shared types and helpers for the shreg_ms multi-stage shift register.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   shreg_mode_t : operation select encoding (hold / forward / backward / load)
//   fill_w()     : width of the fill counter for a given depth
package shreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_FWD  = 2'b01,
        MODE_BWD  = 2'b10,
        MODE_LOAD = 2'b11
    } shreg_mode_t;

    // Counter must represent 0..depth inclusive, hence depth+1 values.
    function automatic int fill_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shreg_stage.sv
// One WIDTH-bit master-slave stage cell with a 4:1 next-value mux.
// Latency: 1 clk from mux input to q.
// Backpressure: none; en=0 holds the stored word.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous reset, active-high, clears q
//   en       : update enable; 0 holds
//   sel      : next-value select (hold / left neighbour / right neighbour / load)
//   i_left   : value arriving on a forward shift
//   i_right  : value arriving on a backward shift
//   i_load   : parallel load value
//   o_q      : stored word
module shreg_stage
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  shreg_mode_t      sel,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    input  logic [WIDTH-1:0] i_load,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_q;
        case (sel)
            MODE_HOLD: w_next = r_q;
            MODE_FWD:  w_next = i_left;
            MODE_BWD:  w_next = i_right;
            MODE_LOAD: w_next = i_load;
            default:   w_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shreg_ms.sv
// Parametrised DEPTH x WIDTH shift register (hold/fwd/bwd/load, optional rotate) with saturating fill count.
// Latency: 1 clk per operation; sin_f->sout_f and sin_b->sout_b take DEPTH shift edges, pin->pout 1 edge.
// Backpressure: none; en=0 freezes all stages and the fill counter.
//
// Build option: define SHREG_ROTATE_EN to make rot=1 turn FWD/BWD shifts into rotates.
// Without it the rotate muxing is absent and rot is ignored; the port list is the same.
//
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   en         : operation enable (0 = hold)
//   mode       : shreg_mode_t encoding (00 hold, 01 fwd, 10 bwd, 11 load)
//   rot        : rotate select for shifts
//   sin_f/b    : serial inputs for forward (into stage 0) / backward (into stage DEPTH-1)
//   pin        : parallel load data, stage i at [i*WIDTH +: WIDTH]
//   sout_f/b   : stage DEPTH-1 / stage 0
//   pout       : all stages, stage i at [i*WIDTH +: WIDTH]
//   fill, full : words written since reset (saturates at DEPTH), fill == DEPTH
module shreg_ms
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         rot,
    input  logic [WIDTH-1:0]             sin_f,
    input  logic [WIDTH-1:0]             sin_b,
    input  logic [DEPTH*WIDTH-1:0]       pin,
    output logic [WIDTH-1:0]             sout_f,
    output logic [WIDTH-1:0]             sout_b,
    output logic [DEPTH*WIDTH-1:0]       pout,
    output logic [fill_w(DEPTH)-1:0]     fill,
    output logic                         full
);

    localparam int FW = fill_w(DEPTH);
    localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);

    shreg_mode_t      w_mode;
    logic             w_rot;
    logic [WIDTH-1:0] w_stage [DEPTH];
    logic [FW-1:0]    r_fill;

    assign w_mode = shreg_mode_t'(mode);

`ifdef SHREG_ROTATE_EN
    assign w_rot = rot;
`else
    // Rotate disabled: rot is still referenced so the port stays live, but is forced low.
    assign w_rot = rot & 1'b0;
`endif

    // Stage array. End stages take either the serial input or, when rotating,
    // the word from the opposite end. For DEPTH=1 a rotate feeds the stage its
    // own value, which leaves it unchanged.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_left;
        logic [WIDTH-1:0] w_right;

        if (i == 0) begin : g_left_end
            assign w_left = w_rot ? w_stage[DEPTH-1] : sin_f;
        end else begin : g_left_mid
            assign w_left = w_stage[i-1];
        end

        if (i == DEPTH-1) begin : g_right_end
            assign w_right = w_rot ? w_stage[0] : sin_b;
        end else begin : g_right_mid
            assign w_right = w_stage[i+1];
        end

        shreg_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .sel     (w_mode),
            .i_left  (w_left),
            .i_right (w_right),
            .i_load  (pin[i*WIDTH +: WIDTH]),
            .o_q     (w_stage[i])
        );

        assign pout[i*WIDTH +: WIDTH] = w_stage[i];
    end

    // Fill counts words entering from outside. A rotate only recirculates
    // stored words, so it leaves fill alone. Saturates at DEPTH; never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill <= '0;
        end else if (en) begin
            case (w_mode)
                MODE_LOAD: r_fill <= DEPTH_C;
                MODE_FWD,
                MODE_BWD: begin
                    if (!w_rot && (r_fill != DEPTH_C)) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign sout_f = w_stage[DEPTH-1];
    assign sout_b = w_stage[0];
    assign fill   = r_fill;
    assign full   = (r_fill == DEPTH_C);

endmodule

// File: tb/tb_shreg_ms.sv
// Directed self-checking bench for shreg_ms: a DEPTH=4 and a DEPTH=1 instance.
// Latency: inputs driven after negedge, results checked at the following negedge.
// Backpressure: n/a.
module tb_shreg_ms;

    logic        clk = 1'b0;
    logic        rst;

    // DEPTH=4 instance
    logic        a_en;
    logic [1:0]  a_mode;
    logic        a_rot;
    logic [7:0]  a_sin_f, a_sin_b;
    logic [31:0] a_pin;
    logic [7:0]  a_sout_f, a_sout_b;
    logic [31:0] a_pout;
    logic [2:0]  a_fill;
    logic        a_full;

    // DEPTH=1 instance
    logic        b_en;
    logic [1:0]  b_mode;
    logic        b_rot;
    logic [7:0]  b_sin_f, b_sin_b;
    logic [7:0]  b_pin;
    logic [7:0]  b_sout_f, b_sout_b;
    logic [7:0]  b_pout;
    logic [0:0]  b_fill;
    logic        b_full;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shreg_ms #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .en     (a_en),
        .mode   (a_mode),
        .rot    (a_rot),
        .sin_f  (a_sin_f),
        .sin_b  (a_sin_b),
        .pin    (a_pin),
        .sout_f (a_sout_f),
        .sout_b (a_sout_b),
        .pout   (a_pout),
        .fill   (a_fill),
        .full   (a_full)
    );

    shreg_ms #(.WIDTH(8), .DEPTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .en     (b_en),
        .mode   (b_mode),
        .rot    (b_rot),
        .sin_f  (b_sin_f),
        .sin_b  (b_sin_b),
        .pin    (b_pin),
        .sout_f (b_sout_f),
        .sout_b (b_sout_b),
        .pout   (b_pout),
        .fill   (b_fill),
        .full   (b_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for checking/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_op(input logic [1:0] m, input logic r, input logic [7:0] sf,
                        input logic [7:0] sb, input logic [31:0] p);
        a_en = 1'b1; a_mode = m; a_rot = r; a_sin_f = sf; a_sin_b = sb; a_pin = p;
        step();
        a_en = 1'b0; a_mode = 2'b00; a_rot = 1'b0;
    endtask

    task automatic b_op(input logic [1:0] m, input logic r, input logic [7:0] sf,
                        input logic [7:0] sb);
        b_en = 1'b1; b_mode = m; b_rot = r; b_sin_f = sf; b_sin_b = sb;
        step();
        b_en = 1'b0; b_mode = 2'b00; b_rot = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_en = 1'b0; a_mode = 2'b00; a_rot = 1'b0; a_sin_f = '0; a_sin_b = '0; a_pin = '0;
        b_en = 1'b0; b_mode = 2'b00; b_rot = 1'b0; b_sin_f = '0; b_sin_b = '0; b_pin = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_pout",   a_pout,   32'h0);
        chk("rst_fill",   a_fill,   32'd0);
        chk("rst_full",   a_full,   32'd0);
        chk("rst_sout_f", a_sout_f, 32'h0);
        chk("rst_sout_b", a_sout_b, 32'h0);

        // Forward fill with 11,22,33,44
        a_op(2'b01, 1'b0, 8'h11, 8'h00, 32'h0);
        chk("fwd1_fill", a_fill, 32'd1);
        chk("fwd1_full", a_full, 32'd0);
        a_op(2'b01, 1'b0, 8'h22, 8'h00, 32'h0);
        chk("fwd2_fill", a_fill, 32'd2);
        a_op(2'b01, 1'b0, 8'h33, 8'h00, 32'h0);
        chk("fwd3_fill", a_fill, 32'd3);
        chk("fwd3_full", a_full, 32'd0);
        a_op(2'b01, 1'b0, 8'h44, 8'h00, 32'h0);
        chk("fwd4_fill",   a_fill,   32'd4);
        chk("fwd4_full",   a_full,   32'd1);
        chk("fwd4_pout",   a_pout,   32'h11223344);
        chk("fwd4_sout_f", a_sout_f, 32'h11);
        chk("fwd4_sout_b", a_sout_b, 32'h44);

        // Shift while full: oldest word drops off, fill saturates
        a_op(2'b01, 1'b0, 8'h55, 8'h00, 32'h0);
        chk("fwd5_sout_f", a_sout_f, 32'h22);
        chk("fwd5_fill",   a_fill,   32'd4);
        chk("fwd5_pout",   a_pout,   32'h22334455);

        // en=0 with an active FWD request holds everything
        a_en = 1'b0; a_mode = 2'b01; a_sin_f = 8'h99;
        step(); step(); step();
        a_mode = 2'b00;
        chk("hold_pout", a_pout, 32'h22334455);
        chk("hold_fill", a_fill, 32'd4);

        // Parallel load then backward shift
        a_op(2'b11, 1'b0, 8'h00, 8'h00, 32'hDDCCBBAA);
        chk("load_pout",   a_pout,   32'hDDCCBBAA);
        chk("load_sout_b", a_sout_b, 32'hAA);
        chk("load_sout_f", a_sout_f, 32'hDD);
        chk("load_fill",   a_fill,   32'd4);
        a_op(2'b10, 1'b0, 8'h00, 8'hEE, 32'h0);
        chk("bwd_pout",   a_pout,   32'hEEDDCCBB);
        chk("bwd_sout_b", a_sout_b, 32'hBB);

        // Reset overrides a concurrent LOAD
        rst = 1'b1; a_en = 1'b1; a_mode = 2'b11; a_pin = 32'hFFFFFFFF;
        step();
        rst = 1'b0; a_en = 1'b0; a_mode = 2'b00;
        chk("rstload_pout", a_pout, 32'h0);
        chk("rstload_fill", a_fill, 32'd0);
        chk("rstload_full", a_full, 32'd0);

        // Partial fill from the backward end
        a_op(2'b10, 1'b0, 8'h00, 8'h77, 32'h0);
        chk("bwd1_fill",   a_fill,   32'd1);
        chk("bwd1_full",   a_full,   32'd0);
        chk("bwd1_pout",   a_pout,   32'h77000000);
        chk("bwd1_sout_f", a_sout_f, 32'h77);

        // LOAD after partial fill jumps straight to full
        a_op(2'b11, 1'b0, 8'h00, 8'h00, 32'hDDCCBBAA);
        chk("reload_fill", a_fill, 32'd4);
        chk("reload_full", a_full, 32'd1);

        // Forward rotate (or plain shift of zeros when rotate is compiled out)
        a_op(2'b01, 1'b1, 8'h00, 8'h00, 32'h0);
`ifdef SHREG_ROTATE_EN
        chk("rotf1_pout", a_pout, 32'hCCBBAADD);
`else
        chk("rotf1_pout", a_pout, 32'hCCBBAA00);
`endif
        chk("rotf1_fill", a_fill, 32'd4);
        a_op(2'b01, 1'b1, 8'h00, 8'h00, 32'h0);
        a_op(2'b01, 1'b1, 8'h00, 8'h00, 32'h0);
        a_op(2'b01, 1'b1, 8'h00, 8'h00, 32'h0);
`ifdef SHREG_ROTATE_EN
        chk("rotf4_pout", a_pout, 32'hDDCCBBAA);
`else
        chk("rotf4_pout", a_pout, 32'h00000000);
`endif
        chk("rotf4_fill", a_fill, 32'd4);

        // Backward rotate; rot in LOAD is ignored
        a_op(2'b11, 1'b1, 8'h00, 8'h00, 32'hDDCCBBAA);
        chk("rotload_pout", a_pout, 32'hDDCCBBAA);
        a_op(2'b10, 1'b1, 8'h00, 8'h00, 32'h0);
`ifdef SHREG_ROTATE_EN
        chk("rotb1_pout", a_pout, 32'hAADDCCBB);
`else
        chk("rotb1_pout", a_pout, 32'h00DDCCBB);
`endif

        // Rotate while partially filled must not advance fill
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_op(2'b01, 1'b0, 8'h12, 8'h00, 32'h0);
        a_op(2'b01, 1'b1, 8'h34, 8'h00, 32'h0);
`ifdef SHREG_ROTATE_EN
        chk("rotpart_fill", a_fill, 32'd1);
        chk("rotpart_pout", a_pout, 32'h00001200);
`else
        chk("rotpart_fill", a_fill, 32'd2);
        chk("rotpart_pout", a_pout, 32'h00001234);
`endif

        // DEPTH=1 instance (held in reset state so far)
        chk("d1_rst_pout", b_pout, 32'h0);
        chk("d1_rst_full", b_full, 32'd0);
        b_op(2'b01, 1'b0, 8'h5A, 8'h00);
        chk("d1_fwd_pout", b_pout, 32'h5A);
        chk("d1_fwd_full", b_full, 32'd1);
        chk("d1_fwd_fill", b_fill, 32'd1);
        b_op(2'b10, 1'b0, 8'h00, 8'hA5);
        chk("d1_bwd_pout",   b_pout,   32'hA5);
        chk("d1_bwd_fill",   b_fill,   32'd1);
        chk("d1_bwd_sout_f", b_sout_f, 32'hA5);
        chk("d1_bwd_sout_b", b_sout_b, 32'hA5);
        b_op(2'b01, 1'b1, 8'h33, 8'h00);
`ifdef SHREG_ROTATE_EN
        chk("d1_rot_pout", b_pout, 32'hA5);
`else
        chk("d1_rot_pout", b_pout, 32'h33);
`endif
        chk("d1_rot_fill", b_fill, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
